frac_clk_div: RTL and testbench

Runtime-programmable fractional clock divider. It generates an output clock whose average period is INT + NUM/DEN input cycles, using dual-modulus periods of INT or INT+1 cycles selected by a first-order accumulator. Period lengths are spread evenly across each sequence. It is the parametrised successor of the fixed 8.7 divider. Reset defaults reproduce 8.7 exactly: 87 input cycles per 10 output periods. The block sits in the clocking and timing area and drives enable-style clock-domain logic. It also provides a per-period strobe.

---
 rtl/frac_clk_div.sv | 176 +++++++++++++++++
 tb/tb_frac_clk_div.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : frac_clk_div
//  Description : Runtime-programmable fractional clock divider. Produces an
//                output clock whose average period is INT + NUM/DEN input
//                cycles. Each period is INT or INT+1 cycles long, chosen by a
//                first-order accumulator, so long and short periods are spread
//                evenly. A per-period strobe marks the last cycle of each
//                period. New settings arrive through a valid/ready handshake
//                and take effect at the next period boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module frac_clk_div #(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int DEF_INT = 8,
    parameter int DEF_NUM = 7,
    parameter int DEF_DEN = 10
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_num,
    input  logic [FRAC_W-1:0] cfg_den,
    output logic              cfg_err,
    output logic              clk_out,
    output logic              clk_pulse,
    output logic [INT_W:0]    cur_len
);

    // Reset state equals one start step applied from an empty accumulator
    // using the default configuration.
    localparam logic [FRAC_W:0] c_RST_SUM   = (FRAC_W+1)'(DEF_NUM);
    localparam logic            c_RST_CARRY = (c_RST_SUM >= (FRAC_W+1)'(DEF_DEN));
    localparam logic [INT_W:0]  c_RST_LEN   = (INT_W+1)'(DEF_INT) + (INT_W+1)'(c_RST_CARRY);
    localparam logic [FRAC_W-1:0] c_RST_ACC = c_RST_CARRY ? FRAC_W'(DEF_NUM - DEF_DEN)
                                                          : FRAC_W'(DEF_NUM);
    localparam logic [INT_W:0]  c_LEN_ONE   = (INT_W+1)'(1);

    // Active and shadow configuration
    logic [INT_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_num;
    logic [FRAC_W-1:0] r_act_den;
    logic [INT_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_num;
    logic [FRAC_W-1:0] r_sh_den;
    logic              r_pending;

    // Period generator state
    logic [INT_W:0]    r_cnt;
    logic [INT_W:0]    r_len;
    logic [FRAC_W-1:0] r_acc;
    logic              r_clk_out;
    logic              r_pulse;
    logic              r_err;

    // Combinational next-state terms
    logic              w_last;
    logic              w_apply;
    logic              w_accept;
    logic              w_legal;
    logic [INT_W-1:0]  w_use_int;
    logic [FRAC_W-1:0] w_use_num;
    logic [FRAC_W-1:0] w_use_den;
    logic [FRAC_W-1:0] w_seed;
    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W:0]   w_diff;
    logic [INT_W:0]    w_step_len;
    logic [FRAC_W-1:0] w_step_acc;
    logic [INT_W:0]    w_cnt_nxt;
    logic [INT_W:0]    w_len_nxt;
    logic [FRAC_W-1:0] w_acc_nxt;
    logic              w_out_nxt;
    logic              w_pulse_nxt;

    // Handshake qualification: accept only when nothing is pending, and vet
    // the offered values before they may reach the shadow registers.
    always_comb begin
        w_accept = cfg_valid && !r_pending;
        w_legal  = (cfg_int >= INT_W'(2)) && (cfg_den != '0) && (cfg_num < cfg_den);
    end

    // Start step: choose the configuration and accumulator seed, then decide
    // between a short (INT) and long (INT+1) period.
    always_comb begin
        w_last    = (r_cnt == (r_len - c_LEN_ONE));
        w_apply   = r_pending && (!en || w_last);
        w_use_int = w_apply ? r_sh_int : r_act_int;
        w_use_num = w_apply ? r_sh_num : r_act_num;
        w_use_den = w_apply ? r_sh_den : r_act_den;
        // A new sequence (disabled or freshly applied) starts from acc=0
        w_seed    = (!en || w_apply) ? '0 : r_acc;
        w_sum     = {1'b0, w_seed} + {1'b0, w_use_num};
        w_diff    = w_sum - {1'b0, w_use_den};
        if (w_sum >= {1'b0, w_use_den}) begin
            w_step_len = {1'b0, w_use_int} + c_LEN_ONE;
            w_step_acc = w_diff[FRAC_W-1:0];
        end else begin
            w_step_len = {1'b0, w_use_int};
            w_step_acc = w_sum[FRAC_W-1:0];
        end
    end

    // Counter advance; outputs are derived from the next state so the
    // registered clk_out/clk_pulse line up with the registered count.
    always_comb begin
        w_cnt_nxt = r_cnt + c_LEN_ONE;
        w_len_nxt = r_len;
        w_acc_nxt = r_acc;
        if (!en || w_last) begin
            w_cnt_nxt = '0;
            w_len_nxt = w_step_len;
            w_acc_nxt = w_step_acc;
        end
        w_out_nxt   = en && (w_cnt_nxt >= (w_len_nxt >> 1));
        w_pulse_nxt = en && (w_cnt_nxt == (w_len_nxt - c_LEN_ONE));
    end

    // Period generator registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt     <= '0;
            r_len     <= c_RST_LEN;
            r_acc     <= c_RST_ACC;
            r_clk_out <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_acc     <= w_acc_nxt;
            r_clk_out <= w_out_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    // Configuration registers: shadow capture, apply at boundary, error pulse
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_act_int <= INT_W'(DEF_INT);
            r_act_num <= FRAC_W'(DEF_NUM);
            r_act_den <= FRAC_W'(DEF_DEN);
            r_sh_int  <= '0;
            r_sh_num  <= '0;
            r_sh_den  <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_apply) begin
                r_act_int <= r_sh_int;
                r_act_num <= r_sh_num;
                r_act_den <= r_sh_den;
            end
            // Accept and apply are exclusive: accept needs pending=0
            if (w_accept && w_legal) begin
                r_sh_int  <= cfg_int;
                r_sh_num  <= cfg_num;
                r_sh_den  <= cfg_den;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cfg_ready = !r_pending;
    assign cfg_err   = r_err;
    assign clk_out   = r_clk_out;
    assign clk_pulse = r_pulse;
    assign cur_len   = r_len;

endmodule
`default_nettype wire

// File: tb/tb_frac_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frac_clk_div
//  Description : Self-checking bench for frac_clk_div. A reference model
//                tracks period index and position, deriving each period
//                length from the closed form
//                INT + floor((k+1)*NUM/DEN) - floor(k*NUM/DEN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frac_clk_div;

    localparam int c_INT_W  = 8;
    localparam int c_FRAC_W = 8;

    logic                clk_in;
    logic                rst;
    logic                en;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [c_INT_W-1:0]  cfg_int;
    logic [c_FRAC_W-1:0] cfg_num;
    logic [c_FRAC_W-1:0] cfg_den;
    logic                cfg_err;
    logic                clk_out;
    logic                clk_pulse;
    logic [c_INT_W:0]    cur_len;

    frac_clk_div #(
        .INT_W   (c_INT_W),
        .FRAC_W  (c_FRAC_W),
        .DEF_INT (8),
        .DEF_NUM (7),
        .DEF_DEN (10)
    ) u_dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .clk_pulse (clk_pulse),
        .cur_len   (cur_len)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks;
    int n_fail;
    int n_pulses;

    // Reference model state
    int m_int, m_num, m_den;
    int s_int, s_num, s_den;
    bit m_pend;
    bit m_err;
    int m_k;
    int m_p;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_len();
        return m_int + ((m_k + 1) * m_num) / m_den - (m_k * m_num) / m_den;
    endfunction

    // Advance the model by one rising edge with the given inputs
    task automatic model_step(input bit r, input bit e, input bit v,
                              input int ci, input int cn, input int cd);
        int  len;
        bit  acc_ok;
        bit  legal;
        if (r) begin
            m_int = 8; m_num = 7; m_den = 10;
            s_int = 0; s_num = 0; s_den = 0;
            m_pend = 0; m_err = 0; m_k = 0; m_p = 0;
        end else begin
            acc_ok = v && !m_pend;
            legal  = (ci >= 2) && (cd != 0) && (cn < cd);
            m_err  = acc_ok && !legal;
            len    = exp_len();
            if (!e) begin
                if (m_pend) begin
                    m_int = s_int; m_num = s_num; m_den = s_den; m_pend = 0;
                end
                m_k = 0; m_p = 0;
            end else if (m_p == len - 1) begin
                m_p = 0;
                if (m_pend) begin
                    m_int = s_int; m_num = s_num; m_den = s_den; m_pend = 0;
                    m_k = 0;
                end else begin
                    m_k = (m_k + 1) % m_den;
                end
            end else begin
                m_p++;
            end
            if (acc_ok && legal) begin
                s_int = ci; s_num = cn; s_den = cd; m_pend = 1;
            end
        end
    endtask

    // One clock: compare outputs at the falling edge, drive new inputs,
    // advance the model, then move to the next falling edge.
    task automatic cycle(input bit r, input bit e, input bit v,
                         input int ci, input int cn, input int cd);
        int len;
        len = exp_len();
        check_val("cur_len",   int'(cur_len),   len);
        check_val("clk_out",   int'(clk_out),   (m_p >= len / 2) ? 1 : 0);
        check_val("clk_pulse", int'(clk_pulse), (m_p == len - 1) ? 1 : 0);
        check_val("cfg_ready", int'(cfg_ready), m_pend ? 0 : 1);
        check_val("cfg_err",   int'(cfg_err),   m_err ? 1 : 0);
        if (clk_pulse) n_pulses++;
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_int   = c_INT_W'(ci);
        cfg_num   = c_FRAC_W'(cn);
        cfg_den   = c_FRAC_W'(cd);
        model_step(r, e, v, ci, cn, cd);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) cycle(1'b0, e, 1'b0, 0, 0, 0);
    endtask

    task automatic offer(input bit e, input int ci, input int cn, input int cd);
        cycle(1'b0, e, 1'b1, ci, cn, cd);
    endtask

    int en_left;
    bit en_cur;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_pulses = 0;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_int = '0; cfg_num = '0; cfg_den = '0;
        model_step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);

        // Default 8.7 sequence: 87 cycles per 10 periods
        run(870, 1'b1);
        check_val("pulse_count_870", n_pulses, 100);

        // Integer divide applied mid-period
        run(3, 1'b1);
        offer(1'b1, 5, 0, 1);
        run(40, 1'b1);

        // Alternating 3/4, then an illegal int
        offer(1'b1, 3, 1, 2);
        run(30, 1'b1);
        offer(1'b1, 1, 0, 1);
        run(10, 1'b1);

        // num>=den and den=0 rejected; second config held off while pending
        offer(1'b1, 4, 4, 4);
        offer(1'b1, 4, 0, 0);
        offer(1'b1, 6, 1, 3);
        for (int i = 0; i < 20; i++) offer(1'b1, 7, 2, 5);
        run(40, 1'b1);

        // Enable drop mid-sequence
        run(10, 1'b0);
        run(100, 1'b1);

        // Reset with a configuration pending
        offer(1'b1, 9, 1, 2);
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
        run(100, 1'b1);

        // Largest integer part with a carry gives a 256-cycle period
        offer(1'b1, 255, 1, 2);
        run(600, 1'b1);

        // Randomized traffic
        en_left = 0;
        en_cur  = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int sel, ci, cn, cd;
            bit r, v;
            r = ($urandom_range(0, 499) == 0);
            if (en_left == 0) begin
                en_cur  = ($urandom_range(0, 3) != 0);
                en_left = int'($urandom_range(1, 60));
            end
            en_left--;
            v   = ($urandom_range(0, 11) == 0);
            sel = int'($urandom_range(0, 9));
            ci  = int'($urandom_range(2, 12));
            cd  = int'($urandom_range(1, 12));
            cn  = int'($urandom_range(0, cd));
            if (sel == 0) begin
                ci = 255; cd = 4; cn = int'($urandom_range(0, 3));
            end else if (sel == 1) begin
                ci = int'($urandom_range(0, 1));
            end else if (sel == 2) begin
                cd = 0;
            end
            cycle(r, en_cur, v, ci, cn, cd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
